aes_encipher_core: RTL

//  Iterative AES-128 encipher datapath; one round per clock. Sits directly downstream of the
//  key-expansion block and consumes its round_key_0..10 and ready outputs. Accepts one 128-bit

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/aes_sbox.sv | 29 ++
 rtl/aes_encipher_core.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// AES-128 shared definitions: round count, FSM encoding and the
// GF(2^8) / byte-permutation helpers used by the encipher datapath.
// Contents:
//   NR          number of rounds (AES-128)
//   aes_state_e IDLE / ROUND / DONE
//   xtime       multiply by x in GF(2^8), poly 0x11b
//   mix_column  MixColumns on one 32-bit column (row0 in [31:24])
//   shift_rows  ShiftRows on a 128-bit state (byte0 in [127:120])
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        // 3*x is expressed as xtime(x) ^ x
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Byte (r,c) lives at index r+4c; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Ports: a (input byte), y (substituted byte).
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[a];

endmodule

// File: rtl/aes_encipher_core.sv
// Iterative AES-128 encipher, one round per clock, valid/ready on both
// sides. Round keys come straight from the key-expansion block.
// Ports: clk, reset_n (async, active-low), keys_ready,
//   round_key_0..round_key_10, in_valid/in_ready/in_block,
//   out_valid/out_ready/out_block, abort (only with AES_ENC_ABORT_EN).
// Macro AES_ENC_ABORT_EN adds the abort input.
module aes_encipher_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         keys_ready,
    input  logic [127:0] round_key_0,
    input  logic [127:0] round_key_1,
    input  logic [127:0] round_key_2,
    input  logic [127:0] round_key_3,
    input  logic [127:0] round_key_4,
    input  logic [127:0] round_key_5,
    input  logic [127:0] round_key_6,
    input  logic [127:0] round_key_7,
    input  logic [127:0] round_key_8,
    input  logic [127:0] round_key_9,
    input  logic [127:0] round_key_10,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
`ifdef AES_ENC_ABORT_EN
    input  logic         abort,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block
);

    aes_state_e   st_q, st_d;
    logic [3:0]   rnd_q;
    logic [127:0] state_q;
    logic [127:0] out_q;

    logic         abort_i;
    logic         kill;
    logic         last;
    logic         accept;
    logic         step;
    logic         finish;

    logic [127:0] rk;
    logic [127:0] sub;
    logic [127:0] sr;
    logic [127:0] mc;

`ifdef AES_ENC_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign last = (rnd_q == 4'(NR));

    always_comb begin
        unique case (rnd_q)
            4'd1:    rk = round_key_1;
            4'd2:    rk = round_key_2;
            4'd3:    rk = round_key_3;
            4'd4:    rk = round_key_4;
            4'd5:    rk = round_key_5;
            4'd6:    rk = round_key_6;
            4'd7:    rk = round_key_7;
            4'd8:    rk = round_key_8;
            4'd9:    rk = round_key_9;
            default: rk = round_key_10;
        endcase
    end

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a (state_q[8*g +: 8]),
            .y (sub[8*g +: 8])
        );
    end

    assign sr = shift_rows(sub);

    always_comb begin
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) st_q <= IDLE;
        else          st_q <= st_d;
    end

    // Output / control decode. Losing the keys only kills an
    // in-flight block; a finished result is still delivered.
    always_comb begin
        kill      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (st_q)
            IDLE: begin
                in_ready = keys_ready;
            end
            ROUND: begin
                kill = !keys_ready || abort_i;
            end
            DONE: begin
                kill      = abort_i;
                out_valid = 1'b1;
                in_ready  = keys_ready && out_ready && !abort_i;
            end
            default: begin
                kill = 1'b1;
            end
        endcase
        accept = in_valid && in_ready;
        step   = (st_q == ROUND) && !kill && !last;
        finish = (st_q == ROUND) && !kill && last;
    end

    // Next-state logic
    always_comb begin
        st_d = st_q;
        unique case (st_q)
            IDLE: begin
                if (accept) st_d = ROUND;
            end
            ROUND: begin
                if (kill)      st_d = IDLE;
                else if (last) st_d = DONE;
            end
            DONE: begin
                if (kill)           st_d = IDLE;
                else if (accept)    st_d = ROUND;
                else if (out_ready) st_d = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rnd_q   <= '0;
            state_q <= '0;
            out_q   <= '0;
        end else begin
            if (accept) begin
                state_q <= in_block ^ round_key_0;
                rnd_q   <= 4'd1;
            end else if (step) begin
                state_q <= mc ^ rk;
                rnd_q   <= rnd_q + 4'd1;
            end else if (kill || finish) begin
                rnd_q   <= '0;
            end
            if (finish) out_q <= sr ^ rk;
        end
    end

    assign out_block = out_q;

endmodule
